umbral_sensores: RTL and testbench

Threshold detector with hysteresis and a persistence filter. It converts raw sampled temperature and humidity values into the debounced T and H flags consumed by the downstream alarm state machine. It sits directly upstream of that machine: its T and H outputs wire straight to the machine's T and H inputs. Each channel runs an independent 4-state FSM, so a single noisy sample can never toggle a flag.

---
 rtl/umbral_sensores_if.sv | 24 ++
 rtl/umbral_sensores.sv | 137 +++++++++++++
 tb/tb_umbral_sensores.sv | 120 ++++++++++++
 3 files changed

// File: rtl/umbral_sensores_if.sv
// Sample bus into the threshold detector and debounced flags out of it.
interface umbral_sensores_if #(
    parameter int DATA_W = 8
);
    logic              sample_valid;
    logic [DATA_W-1:0] temp_in;
    logic [DATA_W-1:0] hum_in;
    logic              T;
    logic              H;
    logic              t_change;
    logic              h_change;

    // Sensor front end: drives samples, observes flags.
    modport master (
        output sample_valid, temp_in, hum_in,
        input  T, H, t_change, h_change
    );

    // Detector: consumes samples, drives flags.
    modport slave (
        input  sample_valid, temp_in, hum_in,
        output T, H, t_change, h_change
    );
endinterface

// File: rtl/umbral_sensores.sv
// Threshold detector with hysteresis and persistence filter for the
// temperature (T) and humidity (H) flags feeding the alarm FSM.
//
// state    | meaning
// ---------+---------------------------------------------------------
// BAJO     | flag 0, no qualifying streak
// SUBIENDO | flag 0, counting consecutive samples >= HIGH
// ALTO     | flag 1, no qualifying streak
// BAJANDO  | flag 1, counting consecutive samples <= LOW
module umbral_sensores #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 4,
    parameter int PERSIST = 3,
    parameter int T_HIGH  = 40,
    parameter int T_LOW   = 35,
    parameter int H_HIGH  = 80,
    parameter int H_LOW   = 70
) (
    input logic                 clock,
    input logic                 reset,
    umbral_sensores_if.slave    bus
);

    typedef enum logic [1:0] {
        BAJO     = 2'd0,
        SUBIENDO = 2'd1,
        ALTO     = 2'd2,
        BAJANDO  = 2'd3
    } estado_t;

    localparam logic [CNT_W:0]   PERSIST_C = (CNT_W+1)'(PERSIST);
    localparam bool_one          = (PERSIST == 1);
    // Count loaded on the first qualifying sample; with PERSIST == 1 the
    // streak completes at once, so the counter is left at 0.
    localparam logic [CNT_W-1:0] CNT_FIRST = bool_one ? '0 : CNT_W'(1);

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam logic [DATA_W-1:0] HIGH = (g == 0) ? DATA_W'(T_HIGH) : DATA_W'(H_HIGH);
        localparam logic [DATA_W-1:0] LOW  = (g == 0) ? DATA_W'(T_LOW)  : DATA_W'(H_LOW);

        estado_t           state_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              flag_q;
        logic              chg_q;
        logic [DATA_W-1:0] x;
        logic              q_set;
        logic              q_clr;
        logic              streak_done;

        assign x           = (g == 0) ? bus.temp_in : bus.hum_in;
        assign q_set       = (x >= HIGH);
        assign q_clr       = (x <= LOW);
        assign streak_done = (({1'b0, cnt_q} + 1'b1) == PERSIST_C);

        // Per-channel FSM with registered flag and one-cycle change pulse.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= BAJO;
                cnt_q   <= '0;
                flag_q  <= 1'b0;
                chg_q   <= 1'b0;
            end else begin
                chg_q <= 1'b0;
                if (bus.sample_valid) begin
                    case (state_q)
                        BAJO: begin
                            if (q_set) begin
                                cnt_q <= CNT_FIRST;
                                if (bool_one) begin
                                    state_q <= ALTO;
                                    flag_q  <= 1'b1;
                                    chg_q   <= 1'b1;
                                end else begin
                                    state_q <= SUBIENDO;
                                end
                            end else begin
                                cnt_q <= '0;
                            end
                        end
                        SUBIENDO: begin
                            if (!q_set) begin
                                state_q <= BAJO;
                                cnt_q   <= '0;
                            end else if (streak_done) begin
                                state_q <= ALTO;
                                cnt_q   <= '0;
                                flag_q  <= 1'b1;
                                chg_q   <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        ALTO: begin
                            if (q_clr) begin
                                cnt_q <= CNT_FIRST;
                                if (bool_one) begin
                                    state_q <= BAJO;
                                    flag_q  <= 1'b0;
                                    chg_q   <= 1'b1;
                                end else begin
                                    state_q <= BAJANDO;
                                end
                            end
                        end
                        BAJANDO: begin
                            if (!q_clr) begin
                                state_q <= ALTO;
                                cnt_q   <= '0;
                            end else if (streak_done) begin
                                state_q <= BAJO;
                                cnt_q   <= '0;
                                flag_q  <= 1'b0;
                                chg_q   <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= BAJO;
                            cnt_q   <= '0;
                            flag_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        if (g == 0) begin : g_t
            assign bus.T        = flag_q;
            assign bus.t_change = chg_q;
        end else begin : g_h
            assign bus.H        = flag_q;
            assign bus.h_change = chg_q;
        end
    end

endmodule

// File: tb/tb_umbral_sensores.sv
// Directed bench for umbral_sensores with hand-computed expectations.
module tb_umbral_sensores;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    umbral_sensores_if #(.DATA_W(8)) bus ();

    umbral_sensores dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One cycle: drive on the falling edge, settle just after the rising edge.
    task automatic step(input logic r, input logic v, input int t, input int h);
        @(negedge clock);
        reset            = r;
        bus.sample_valid = v;
        bus.temp_in      = 8'(t);
        bus.hum_in       = 8'(h);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic et, input logic etc,
                           input logic eh, input logic ehc);
        chk({tag, ".T"},  bus.T,        et);
        chk({tag, ".tc"}, bus.t_change, etc);
        chk({tag, ".H"},  bus.H,        eh);
        chk({tag, ".hc"}, bus.h_change, ehc);
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.temp_in      = '0;
        bus.hum_in       = '0;

        // Reset held with qualifying data present
        step(1, 1, 50, 90); chk_all("rst0", 0, 0, 0, 0);
        step(1, 1, 50, 90); chk_all("rst1", 0, 0, 0, 0);

        // Set T at the boundary value
        step(0, 1, 40, 50); chk_all("set1", 0, 0, 0, 0);
        step(0, 1, 40, 50); chk_all("set2", 0, 0, 0, 0);
        step(0, 1, 40, 50); chk_all("set3", 1, 1, 0, 0);
        step(0, 0, 0, 0);   chk_all("set_idle", 1, 0, 0, 0);

        // Broken streak
        step(1, 0, 0, 0);
        step(0, 1, 45, 50); chk("brk1", bus.T, 0);
        step(0, 1, 45, 50); chk("brk2", bus.T, 0);
        step(0, 1, 30, 50); chk("brk3", bus.T, 0);
        step(0, 1, 45, 50); chk("brk4", bus.T, 0);
        step(0, 1, 45, 50); chk("brk5", bus.T, 0);
        step(0, 1, 45, 50); chk("brk6.T", bus.T, 1); chk("brk6.tc", bus.t_change, 1);

        // Hysteresis band holds the flag
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 36, 50);
            chk("hyst.T", bus.T, 1);
            chk("hyst.tc", bus.t_change, 0);
        end
        // Interrupted clear streak, then full clear
        step(0, 1, 35, 50); chk("clr1", bus.T, 1);
        step(0, 1, 35, 50); chk("clr2", bus.T, 1);
        step(0, 1, 40, 50); chk("clr3", bus.T, 1);
        step(0, 1, 35, 50); chk("clr4", bus.T, 1);
        step(0, 1, 35, 50); chk("clr5", bus.T, 1);
        step(0, 1, 35, 50); chk("clr6.T", bus.T, 0); chk("clr6.tc", bus.t_change, 1);
        step(0, 0, 0, 0);   chk("clr_idle.tc", bus.t_change, 0);

        // Valid samples separated by idle cycles with ignored data
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 50, 50);
            chk("gap_v", bus.T, (k == 2));
            chk("gap_vtc", bus.t_change, (k == 2));
            if (k < 2) begin
                for (int j = 0; j < 4; j++) begin
                    step(0, 0, 0, 0);
                    chk("gap_idle", bus.T, 0);
                end
            end
        end

        // Both channels rise together
        step(1, 0, 0, 0);
        step(0, 1, 40, 80); chk_all("sim1", 0, 0, 0, 0);
        step(0, 1, 40, 80); chk_all("sim2", 0, 0, 0, 0);
        step(0, 1, 40, 80); chk_all("sim3", 1, 1, 1, 1);
        step(0, 0, 0, 0);   chk_all("sim_idle", 1, 0, 1, 0);
        // H clears at its boundary while T stays in its band
        step(0, 1, 36, 70); step(0, 1, 36, 70);
        step(0, 1, 36, 70); chk_all("hclr", 1, 0, 0, 1);

        // Reset mid-count discards the partial streak
        step(1, 0, 0, 0);
        step(0, 1, 50, 50); step(0, 1, 50, 50);
        step(1, 1, 50, 50); chk("midrst_r", bus.T, 0);
        step(0, 1, 50, 50); chk("midrst1", bus.T, 0);
        step(0, 1, 50, 50); chk("midrst2", bus.T, 0);
        step(0, 1, 50, 50); chk("midrst3", bus.T, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
